vram_dump_tx: RTL

Hardware dump engine: on a start pulse it reads a window of 32-bit words from a synchronous-read memory port (VRAM or RAM) and transmits each word over UART as 8 lowercase hex ASCII characters followed by `\n`. This is the on-board counterpart of the simulation dump, so a board run produces the same text format through a serial pin. It sits beside the CPU, on the second read port of the target memory, and drives the board UART TX pin.

---
 rtl/dump_pkg.sv | 23 ++
 rtl/uart_tx_byte.sv | 53 +++++
 rtl/vram_dump_tx.sv | 116 +++++++++++
 3 files changed

// File: rtl/dump_pkg.sv
// rtl/dump_pkg.sv - shared constants, FSM state type and hex-to-ASCII helper for the dump engine
package dump_pkg;

  localparam logic [7:0] NEWLINE = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    SEND,
    NEXT,
    DONE
  } dump_state_t;

  // Lowercase hex digit, matching the %x text of the simulation dump.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h61 + {4'h0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 UART transmitter with valid/ready byte handshake
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic          busy;
  logic [9:0]    shreg;
  logic [BW-1:0] baud;
  logic [3:0]    bit_idx;
  logic          last;

  // Accepting in the final stop-bit cycle lets frames run back-to-back.
  assign last    = busy && (bit_idx == 4'd9) && (baud == BAUD_LAST);
  assign o_ready = !busy || last;
  assign o_tx    = busy ? shreg[0] : 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy    <= 1'b0;
      shreg   <= '1;
      baud    <= '0;
      bit_idx <= '0;
    end else if (i_valid && o_ready) begin
      busy    <= 1'b1;
      shreg   <= {1'b1, i_data, 1'b0};
      baud    <= '0;
      bit_idx <= '0;
    end else if (busy) begin
      if (baud == BAUD_LAST) begin
        baud <= '0;
        if (bit_idx == 4'd9) begin
          busy <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          shreg   <= {1'b1, shreg[9:1]};
        end
      end else begin
        baud <= baud + BW'(1);
      end
    end
  end

endmodule

// File: rtl/vram_dump_tx.sv
// rtl/vram_dump_tx.sv - reads a memory window and sends each word as 8 hex chars plus newline over UART
module vram_dump_tx
  import dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_count,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [31:0]       i_rd_data,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_done
);

  dump_state_t state, state_n;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_inc;
  logic [31:0]       word_q;
  logic [3:0]        ch;
  logic [4:0]        nib_lsb;
  logic [7:0]        tx_char;
  logic              tx_valid;
  logic              tx_ready;
  logic              done_q;

  assign idx_inc   = idx + {{ADDR_W{1'b0}}, 1'b1};
  assign o_rd_addr = base_q + idx[ADDR_W-1:0];
  assign o_busy    = (state != IDLE);
  assign o_done    = done_q;

  // Char 0 is the top nibble; (7 - ch) * 4 reduces to inverting ch for 3 bits.
  assign nib_lsb = {~ch[2:0], 2'b00};
  assign tx_char = (ch == 4'd8) ? NEWLINE : hex_ascii(i_rd_data_word(nib_lsb));

  function automatic logic [3:0] i_rd_data_word(input logic [4:0] lsb);
    return word_q[lsb +: 4];
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    o_rd_en  = 1'b0;
    tx_valid = 1'b0;
    case (state)
      IDLE:  if (i_start) state_n = (i_count == '0) ? DONE : READ;
      READ: begin
        o_rd_en = 1'b1;
        state_n = LATCH;
      end
      LATCH: state_n = SEND;
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready && (ch == 4'd8)) state_n = NEXT;
      end
      NEXT:  state_n = (idx_inc == count_q) ? DONE : READ;
      DONE:  if (tx_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The UART reports ready in the last stop-bit cycle, so done lands right after it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      base_q  <= '0;
      count_q <= '0;
      idx     <= '0;
      word_q  <= '0;
      ch      <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == DONE) && tx_ready;
      case (state)
        IDLE: if (i_start) begin
          base_q  <= i_base;
          count_q <= i_count;
          idx     <= '0;
        end
        LATCH: begin
          word_q <= i_rd_data;
          ch     <= '0;
        end
        SEND: if (tx_ready) ch <= ch + 4'd1;
        NEXT: idx <= idx_inc;
        default: ;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(tx_valid),
    .i_data (tx_char),
    .o_ready(tx_ready),
    .o_tx   (o_tx)
  );

endmodule
